// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO offsets, TX_STATUS bit positions and region decode type
package dmem_pkg;
    localparam logic [7:0] OFF_CYCLE_LO  = 8'h00;
    localparam logic [7:0] OFF_CYCLE_HI  = 8'h04;
    localparam logic [7:0] OFF_TX_DATA   = 8'h08;
    localparam logic [7:0] OFF_TX_STATUS = 8'h0C;
    localparam logic [7:0] OFF_EXIT      = 8'h10;
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_OVERFLOW  = 8;
    typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_UNMAPPED} region_e;
endpackage

// File: rtl/dmem_mmio_ctrl_sync_fifo.sv
// sync_fifo: pointer-based FIFO; a push into a full FIFO is accepted only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH) + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    always_comb begin
        count   = wr_ptr - rd_ptr;
        full    = count == PW'(DEPTH);
        empty   = count == '0;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rd_ptr[PW-2:0]];
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-2:0]] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/dmem_mmio_ctrl.sv
// dmem_mmio_ctrl: byte-writable word RAM plus MMIO window (cycle counter, TX FIFO, exit)
module dmem_mmio_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int          TX_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_read,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] exit_code,
    output logic        addr_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(TX_DEPTH) + 1;
    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    region_e region;
    logic [7:0] off;
    logic access, is_mmio, push, pop, ovf_set, ovf_clr, exit_wr;
    logic [63:0] cycle;
    logic [31:0] cycle_hi, tx_status, mmio_rdata, rdata;
    logic overflow, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    always_comb begin
        idx        = data_addr[AW+1:2];
        off        = data_addr[7:0];
        access     = data_read || data_write != 4'b0;
        region     = data_addr[31:AW+2] == '0 ? REG_RAM :
                     data_addr[31:8] == MMIO_BASE[31:8] ? REG_MMIO : REG_UNMAPPED;
        is_mmio    = region == REG_MMIO;
        pop        = tx_valid && tx_ready;
        push       = is_mmio && off == OFF_TX_DATA && data_write[0];
        ovf_set    = push && fifo_full && !pop;
        ovf_clr    = is_mmio && off == OFF_TX_STATUS && data_write[1] && data_in[8];
        exit_wr    = is_mmio && off == OFF_EXIT && data_write == 4'b1111 && !halt;
        tx_status  = '0;
        tx_status[ST_OVERFLOW]      = overflow;
        tx_status[ST_COUNT_LSB +: 4] = 4'(fifo_count);
        tx_status[ST_FULL]          = fifo_full;
        tx_status[ST_EMPTY]         = fifo_empty;
        mmio_rdata = off == OFF_CYCLE_LO  ? cycle[31:0] :
                     off == OFF_CYCLE_HI  ? cycle_hi :
                     off == OFF_TX_STATUS ? tx_status :
                     off == OFF_EXIT      ? exit_code : 32'h0;
        rdata      = region == REG_RAM ? mem[idx] : is_mmio ? mmio_rdata : 32'h0;
        tx_valid   = !fifo_empty;
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (region == REG_RAM && data_write[i]) mem[idx][8*i +: 8] <= data_in[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            addr_err  <= 1'b0;
            cycle     <= '0;
            cycle_hi  <= '0;
            halt      <= 1'b0;
            exit_code <= '0;
            overflow  <= 1'b0;
        end else begin
            if (data_read) data_out <= rdata;
            addr_err <= access && region == REG_UNMAPPED;
            if (!halt) cycle <= cycle + 64'd1;
            if (data_read && is_mmio && off == OFF_CYCLE_LO) cycle_hi <= cycle[63:32];
            if (exit_wr) begin
                halt      <= 1'b1;
                exit_code <= data_in;
            end
            overflow <= ovf_set ? 1'b1 : ovf_clr ? 1'b0 : overflow;
        end
    end
    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (data_in[7:0]),
        .pop   (pop),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// tb_dmem_mmio_ctrl: directed stimulus checked every cycle against a queue/array reference model
module tb_dmem_mmio_ctrl;
    localparam int DEPTH = 16384;
    localparam logic [31:0] MB = 32'hFFFF_0000;
    logic clk = 0, rst = 1, data_read = 0, tx_ready = 0;
    logic [31:0] data_addr = 0, data_in = 0;
    logic [3:0] data_write = 0;
    logic [31:0] data_out, exit_code;
    logic [7:0] tx_data;
    logic tx_valid, halt, addr_err;
    int n_chk = 0, n_fail = 0;

    dmem_mmio_ctrl dut (
        .clk(clk), .rst(rst), .data_read(data_read), .data_addr(data_addr),
        .data_write(data_write), .data_in(data_in), .data_out(data_out),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .halt(halt), .exit_code(exit_code), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // reference model state
    logic [31:0] m_ram [int];
    logic [7:0] m_q [$];
    logic [31:0] m_dout, m_exit, m_hi, rv, w;
    logic [63:0] m_cycle;
    logic m_err, m_halt, m_ovf, is_ram, is_mmio, acc, pop, push, set, clr, old_halt;
    logic [7:0] off;
    initial begin
        m_dout = 0; m_exit = 0; m_hi = 0; m_cycle = 0; m_err = 0; m_halt = 0; m_ovf = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_dout = 0; m_err = 0; m_halt = 0; m_exit = 0; m_cycle = 0; m_hi = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            acc = data_read || data_write != 0;
            is_ram = data_addr < DEPTH * 4;
            is_mmio = data_addr[31:8] == MB[31:8];
            off = data_addr[7:0];
            rv = 0;
            if (is_ram) rv = m_ram.exists(int'(data_addr >> 2)) ? m_ram[int'(data_addr >> 2)] : 32'h0;
            else if (is_mmio) begin
                if (off == 8'h00) rv = m_cycle[31:0];
                else if (off == 8'h04) rv = m_hi;
                else if (off == 8'h0C)
                    rv = (32'(m_ovf) << 8) | (32'(m_q.size()) << 4)
                       | (32'(m_q.size() == 8) << 1) | 32'(m_q.size() == 0);
                else if (off == 8'h10) rv = m_exit;
            end
            if (data_read) m_dout = rv;
            m_err = acc && !is_ram && !is_mmio;
            if (data_read && is_mmio && off == 8'h00) m_hi = m_cycle[63:32];
            if (is_ram && data_write != 0) begin
                w = m_ram.exists(int'(data_addr >> 2)) ? m_ram[int'(data_addr >> 2)] : 32'h0;
                for (int i = 0; i < 4; i++) if (data_write[i]) w[8*i +: 8] = data_in[8*i +: 8];
                m_ram[int'(data_addr >> 2)] = w;
            end
            pop = m_q.size() > 0 && tx_ready;
            push = is_mmio && off == 8'h08 && data_write[0];
            clr = is_mmio && off == 8'h0C && data_write[1] && data_in[8];
            set = push && m_q.size() == 8 && !pop;
            if (pop) void'(m_q.pop_front());
            if (push && !set) m_q.push_back(data_in[7:0]);
            if (set) m_ovf = 1; else if (clr) m_ovf = 0;
            old_halt = m_halt;
            if (is_mmio && off == 8'h10 && data_write == 4'hF && !m_halt) begin
                m_halt = 1;
                m_exit = data_in;
            end
            if (!old_halt) m_cycle = m_cycle + 1;
        end
        #1;
        chk("data_out", data_out, m_dout);
        chk("addr_err", addr_err, m_err);
        chk("tx_valid", tx_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("tx_data", tx_data, m_q[0]);
        chk("halt", halt, m_halt);
        chk("exit_code", exit_code, m_exit);
    end

    task automatic idle();
        data_read = 0;
        data_write = 0;
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        data_addr = a; data_in = d; data_write = be; data_read = 0;
        @(negedge clk);
        idle();
    endtask
    task automatic rd(input logic [31:0] a);
        data_addr = a; data_read = 1; data_write = 0;
        @(negedge clk);
        idle();
    endtask
    task automatic chk_reset(input string n);
        chk({n, "_data_out"}, data_out, 0);
        chk({n, "_tx_valid"}, tx_valid, 0);
        chk({n, "_halt"}, halt, 0);
        chk({n, "_exit_code"}, exit_code, 0);
        chk({n, "_addr_err"}, addr_err, 0);
    endtask

    logic [31:0] c0;
    initial begin
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        rst = 0;
        // byte lanes
        wr(32'h100, 32'hDEADBEEF, 4'b1111);
        wr(32'h100, 32'h55555555, 4'b0010);
        rd(32'h100);
        chk("lanes", data_out, 32'hDEAD55EF);
        repeat (3) @(negedge clk);
        chk("lanes_hold", data_out, 32'hDEAD55EF);
        // read-first
        wr(32'h40, 32'h11111111, 4'b1111);
        data_addr = 32'h40; data_in = 32'h22222222; data_write = 4'hF; data_read = 1;
        @(negedge clk);
        idle();
        chk("read_first", data_out, 32'h11111111);
        rd(32'h40);
        chk("after_write", data_out, 32'h22222222);
        // unmapped
        rd(32'h8000_0000);
        chk("unmapped_rd", data_out, 0);
        chk("unmapped_err", addr_err, 1);
        @(negedge clk);
        chk("unmapped_err_pulse", addr_err, 0);
        wr(32'h8000_0100, 32'h0BAD0BAD, 4'b1111);
        rd(32'h100);
        chk("unmapped_wr_ram", data_out, 32'hDEAD55EF);
        rd(MB + 32'h10);
        chk("unmapped_wr_exit", data_out, 0);
        // FIFO overflow and drain
        for (int i = 1; i <= 9; i++) wr(MB + 32'h08, {4{8'(i)}}, 4'b0001);
        rd(MB + 32'h0C);
        chk("status_ovf", data_out, 32'h182);
        tx_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain", tx_data, i);
            @(negedge clk);
        end
        chk("drained", tx_valid, 0);
        tx_ready = 0;
        wr(MB + 32'h0C, 32'h0000_0100, 4'b0010);
        rd(MB + 32'h0C);
        chk("status_clr", data_out, 32'h1);
        // full FIFO with same-cycle push and pop
        for (int i = 0; i < 8; i++) wr(MB + 32'h08, {4{8'(8'h10 + i)}}, 4'b0001);
        data_addr = MB + 32'h08; data_in = {4{8'h18}}; data_write = 4'b0001; tx_ready = 1;
        @(negedge clk);
        idle();
        tx_ready = 0;
        rd(MB + 32'h0C);
        chk("status_pushpop", data_out, 32'h82);
        tx_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("drain2", tx_data, 8'h11 + i);
            @(negedge clk);
        end
        chk("drained2", tx_valid, 0);
        tx_ready = 0;
        // cycle counter from a fresh reset
        wr(MB + 32'h08, 32'h77777777, 4'b0001);
        rst = 1;
        @(negedge clk);
        chk_reset("rst1");
        rst = 0;
        repeat (99) @(negedge clk);
        rd(MB);
        chk("cycle_lo", data_out, 99);
        rd(MB + 32'h04);
        chk("cycle_hi", data_out, 0);
        wr(MB + 32'h10, 32'h0000_0099, 4'b0011);
        chk("exit_partial", halt, 0);
        wr(MB + 32'h10, 32'h0000_002A, 4'b1111);
        chk("halt", halt, 1);
        chk("exit_code", exit_code, 42);
        wr(MB + 32'h10, 32'h0000_0007, 4'b1111);
        chk("exit_sticky", exit_code, 42);
        rd(MB);
        c0 = data_out;
        repeat (5) @(negedge clk);
        rd(MB);
        chk("cycle_frozen", data_out, c0);
        rd(MB + 32'h10);
        chk("exit_rd", data_out, 42);
        // mid-test reset with halt set and FIFO occupied
        wr(MB + 32'h08, 32'h33333333, 4'b0001);
        rd(32'h8000_0000);
        rst = 1;
        @(negedge clk);
        chk_reset("rst2");
        rst = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_mmio_ctrl.md
Name: dmem_mmio_ctrl

Overview:
Data-side memory slave that sits directly downstream of the core's data port. It provides a byte-writable, synchronously read word RAM and a small MMIO window for the bench and system.
- The MMIO window holds a 64-bit cycle counter, an 8-bit TX byte FIFO with a valid/ready drain port, and an exit/halt register.
- Timing matches the core's fixed-latency data access: the strobe is sampled at a posedge, and read data appears on the next posedge and is held.

Parameters:
DEPTH_WORDS, 16384, RAM size in 32-bit words (power of two); RAM decodes byte addresses [0, DEPTH_WORDS*4).
MMIO_BASE, 32'hFFFF_0000, base of the 256-byte MMIO window; decoded on data_addr[31:8].
TX_DEPTH, 8, TX FIFO entries (power of two, >=2).

Ports:
clk  in  1  single clock, all state on posedge
rst  in  1  synchronous, active-high reset
data_read  in  1  read request, sampled each posedge
data_addr  in  32  byte address; word select = data_addr[31:2]
data_write  in  4  byte-lane write enables, bit i -> data_in[8i+7:8i]; 0 = no write
data_in  in  32  write data, already lane-replicated by the core
data_out  out  32  registered read data
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  consumer accepts head when tx_valid && tx_ready
halt  out  1  sticky, set by EXIT write
exit_code  out  32  value written to EXIT
addr_err  out  1  one-cycle pulse on any access to an unmapped address

Behaviour:
- Reset state: data_out=0, tx_valid=0, halt=0, exit_code=0, addr_err=0, FIFO empty, overflow=0, cycle counter=0, hi shadow=0. RAM contents are not reset.
- Access: an access is a posedge with data_read=1 or data_write!=0.
- Region decode:
  - RAM: data_addr < DEPTH_WORDS*4.
  - MMIO: data_addr[31:8]==MMIO_BASE[31:8].
  - Everything else is unmapped.
- RAM write: each enabled lane of the word is updated at the posedge; disabled lanes are unchanged.
- Read latency 1: data_out <= selected word at the sampling posedge, then held until the next read. Cycles without a read never change data_out.
- Read and write to the same word in the same cycle: the write commits, and data_out returns the pre-write word (read-first).
- Unmapped access: writes are dropped. A read loads data_out=0. addr_err=1 for exactly the following cycle.
- MMIO map (offset = data_addr[7:0]; only offsets 0x00-0x10 are defined, others read 0 and ignore writes, no addr_err):
  - 0x00 CYCLE_LO, RO: returns counter[31:0] and latches counter[63:32] into the hi shadow in the same cycle.
  - 0x04 CYCLE_HI, RO: returns the hi shadow.
  - 0x08 TX_DATA, WO: a write with data_write[0]=1 pushes data_in[7:0]. Reads return 0.
  - 0x0C TX_STATUS: read returns {23'b0, overflow[8], count[7:4] (zero-extended), 2'b0, full[1], empty[0]}. A write with data_write[1]=1 and data_in[8]=1 clears overflow.
  - 0x10 EXIT: a write with data_write==4'b1111 sets halt=1 and exit_code=data_in. Once halt=1, further EXIT writes are ignored. Reads return exit_code.
- Cycle counter: +1 every cycle while halt=0; freezes once halt=1; wraps 2^64-1 -> 0.
- TX FIFO:
  - Pointer width log2(TX_DEPTH)+1.
  - tx_data and tx_valid are driven from registered state (no combinational path from tx_ready).
  - Pop when tx_valid && tx_ready.
  - Push while full without a same-cycle pop: the byte is dropped and overflow is set (sticky).
  - Push while full with a same-cycle pop: accepted, count unchanged.
  - Push while empty: tx_valid rises the next cycle; no same-cycle bypass.
  - Overflow clear and overflow set in the same cycle: set wins.
- halt does not block RAM or FIFO traffic; the bench decides when to stop.

Decomposition:
- dmem_pkg holds:
  - MMIO offset constants: OFF_CYCLE_LO, OFF_CYCLE_HI, OFF_TX_DATA, OFF_TX_STATUS, OFF_EXIT.
  - TX_STATUS bit positions.
  - Region-decode enum: REG_RAM, REG_MMIO, REG_UNMAPPED.
- One sub-module, sync_fifo: parameterised width/depth, push/pop/full/empty/count, same-cycle push+pop when full.

Test Plan:
- RAM byte lanes: write 32'hDEADBEEF to 0x100 with 4'b1111, then 32'h00000055 replicated with 4'b0010, then read 0x100 -> data_out=32'hDEAD55EF exactly one cycle after the read strobe, held for 3 idle cycles.
- Read-first: RAM[0x40]=32'h11111111. Same-cycle read + write 32'h22222222 -> data_out=32'h11111111. A following read -> 32'h22222222.
- Unmapped: read 0x8000_0000 -> data_out=0, addr_err high exactly 1 cycle. A write there leaves RAM and MMIO unchanged.
- TX FIFO, tx_ready=0:
  - Push 9 bytes 0x01..0x09 -> TX_STATUS reads 0x00000182 (overflow=1, count=8, full=1).
  - Raise tx_ready -> bytes 0x01..0x08 drain in order over 8 cycles, then tx_valid=0.
  - Clear overflow -> TX_STATUS reads 0x00000001.
- Full FIFO with same-cycle push+pop: count stays 8, no overflow, new byte appears last.
- Cycle counter: after 100 cycles from reset release, CYCLE_LO reads ~100 and CYCLE_HI reads 0. Write EXIT 32'h0000002A with 4'b1111 -> halt=1, exit_code=42, and two later CYCLE_LO reads are equal. A mid-test rst returns every output to its reset value.
